segment_reader: RTL and testbench



---
 rtl/segment_reader.sv | 99 +++++++++
 tb/tb_segment_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_reader.sv
// segment_reader: captures a 16-bit word of four 4-bit segments and streams it out
// one segment per valid/ready transfer, with active-low cumulative clear flags.
// Optional feature: define SEGMENT_READER_PARITY_EN to add the `par` output
// (even parity of L). The default build has no `par` port.
module segment_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] word,
    input  logic        ready,
    output logic [3:0]  L,
    output logic [1:0]  A,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic [3:0]  Clr
`ifdef SEGMENT_READER_PARITY_EN
    ,
    output logic        par
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state;
    logic [15:0] shadow;
    logic [1:0]  a_next;

    // Index of the segment that follows the one currently on the lane
    always_comb begin
        a_next = A + 2'd1;
    end

    // Transfer FSM; every output is a register written here
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            shadow <= 16'h0000;
            L      <= 4'h0;
            A      <= 2'd0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Clr    <= 4'b1111;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        // The shadow copy isolates the transfer from later changes on `word`
                        shadow <= word;
                        L      <= word[3:0];
                        A      <= 2'd0;
                        Clr    <= 4'b1111;
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= StSend;
                    end
                end
                StSend: begin
                    // valid is always high here, so ready alone marks acceptance
                    if (ready) begin
                        Clr[A] <= 1'b0;
                        if (A == 2'd3) begin
                            // A stays at 3; it only returns to 0 on a new start
                            valid <= 1'b0;
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            A <= a_next;
                            L <= shadow[{a_next, 2'b00} +: 4];
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEGMENT_READER_PARITY_EN
    // Parity follows the registered lane, so it is aligned with L every cycle
    assign par = ^L;
`endif

endmodule

// File: tb/tb_segment_reader.sv
// Self-checking bench for segment_reader. Expected segments are queued when a start
// is driven and compared against the lane while valid is high.
module tb_segment_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] word;
    logic        ready;
    logic [3:0]  L;
    logic [1:0]  A;
    logic        valid;
    logic        busy;
    logic        done;
    logic [3:0]  Clr;
`ifdef SEGMENT_READER_PARITY_EN
    logic        par;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] l;
        logic [1:0] a;
        logic [3:0] clr;
    } exp_t;

    exp_t sb[$];

    segment_reader dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .word  (word),
        .ready (ready),
        .L     (L),
        .A     (A),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .Clr   (Clr)
`ifdef SEGMENT_READER_PARITY_EN
        ,
        .par   (par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.l   = w[4*k +: 4];
            e.a   = 2'(k);
            e.clr = 4'b1111 << k;
            sb.push_back(e);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        checks++;
        if (L !== 4'h0 || A !== 2'd0 || valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || Clr !== 4'b1111) begin
            errors++;
            $display("FAIL %s: L=%h A=%0d valid=%b busy=%b done=%b Clr=%b, want 0 0 0 0 0 1111",
                     tag, L, A, valid, busy, done, Clr);
        end
`ifdef SEGMENT_READER_PARITY_EN
        checks++;
        if (par !== 1'b0) begin
            errors++;
            $display("FAIL %s_par: got %b want 0", tag, par);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0; word = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        check_idle_reset("reset_state");
        // start held low: nothing moves
        tick();
        check_idle_reset("idle_hold");
    endtask

    // Runs one transfer starting in the current (idle) cycle. ready is low on cycles
    // stall_lo..stall_hi; disturb changes word and re-pulses start on cycle 2.
    task automatic run_transfer(input logic [15:0] w, input int stall_lo, input int stall_hi,
                                input bit disturb, input int exp_done, input string tag);
        int  done_cyc;
        bit  finished;
        exp_t e;
        done_cyc = -1;
        finished = 1'b0;
        word  = w;
        start = 1'b1;
        ready = 1'b1;
        push_word(w);
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (disturb) begin
                start = (cyc == 2);
                word  = (cyc >= 2) ? 16'hFFFF : w;
            end
            ready = !(cyc >= stall_lo && cyc <= stall_hi);
            if (done === 1'b1) begin
                checks++;
                if (done_cyc != -1 || valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_done_cycle: cyc=%0d prev=%0d valid=%b busy=%b want single pulse valid=0 busy=1",
                             tag, cyc, done_cyc, valid, busy);
                end
                done_cyc = cyc;
            end
            if (busy !== 1'b1) begin
                checks++;
                if (cyc != exp_done + 1) begin
                    errors++;
                    $display("FAIL %s_busy_drop: busy low at cycle %0d want %0d", tag, cyc,
                             exp_done + 1);
                end
                finished = 1'b1;
                break;
            end
            if (valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_seg: L=%h A=%0d with empty scoreboard", tag, L, A);
                end else begin
                    e = sb[0];
                    if (L !== e.l || A !== e.a || Clr !== e.clr) begin
                        errors++;
                        $display("FAIL %s_seg: cyc=%0d got L=%h A=%0d Clr=%b want L=%h A=%0d Clr=%b",
                                 tag, cyc, L, A, Clr, e.l, e.a, e.clr);
                    end
`ifdef SEGMENT_READER_PARITY_EN
                    checks++;
                    if (par !== ^e.l) begin
                        errors++;
                        $display("FAIL %s_par: cyc=%0d got %b want %b", tag, cyc, par, ^e.l);
                    end
`endif
                    if (ready) void'(sb.pop_front());
                end
            end
            tick();
        end
        start = 1'b0;
        word  = w;
        checks++;
        if (!finished || done_cyc != exp_done || sb.size() != 0) begin
            errors++;
            $display("FAIL %s_end: finished=%b done at %0d want %0d, %0d segments left",
                     tag, finished, done_cyc, exp_done, sb.size());
        end
        checks++;
        if (Clr !== 4'b0000 || valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_final: Clr=%b valid=%b want 0000 0", tag, Clr, valid);
        end
        sb.delete();
    endtask

    task automatic test_stream();
        run_transfer(16'hA5C3, 0, -1, 1'b0, 5, "stream");
    endtask

    task automatic test_stall();
        tick();
        run_transfer(16'hA5C3, 2, 3, 1'b0, 7, "stall");
    endtask

    task automatic test_isolation();
        tick();
        run_transfer(16'hA5C3, 0, -1, 1'b1, 5, "isolate");
        // After the transfer Clr stays cleared while idle
        tick();
        checks++;
        if (Clr !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL isolate_idle_hold: Clr=%b busy=%b want 0000 0", Clr, busy);
        end
    endtask

    task automatic test_mid_reset();
        word = 16'h1234; start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        tick();          // cycle 2
        rst = 1'b1;      // cycle 3, sampled at its end
        tick();
        rst = 1'b0;
        check_idle_reset("midrst_state");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (done !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_done: done=%b valid=%b want 0 0", done, valid);
            end
            tick();
        end
        run_transfer(16'hA5C3, 0, -1, 1'b0, 5, "midrst_fresh");
    endtask

    task automatic test_back_to_back();
        tick();
        run_transfer(16'h9D62, 0, -1, 1'b0, 5, "b2b_first");
        // Called straight away: the new start is sampled at the end of cycle 6
        run_transfer(16'h0F81, 1, 1, 1'b0, 6, "b2b_second");
    endtask

`ifdef SEGMENT_READER_PARITY_EN
    task automatic test_parity();
        tick();
        run_transfer(16'h7E10, 0, -1, 1'b0, 5, "parity");
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_isolation();
        test_mid_reset();
        test_back_to_back();
`ifdef SEGMENT_READER_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
